// File: rtl/i2s_apb_streamer.sv
// i2s_apb_streamer
//   APB master that shuttles audio samples between a valid/ready stream
//   interface and a memory-mapped I2S transceiver. The block polls the
//   transceiver status register, then either writes one Tx sample or reads
//   one Rx sample per decision. Tx wins whenever both directions are eligible.
//
// Ports
//   pclk      in   sole clock, rising edge
//   preset    in   asynchronous reset, active-high
//   en        in   enables transfer scheduling
//   tx_data   in   [31:0] sample to transmit
//   tx_valid  in   tx_data is valid
//   tx_ready  out  one-cycle pulse in DECIDE: tx_data accepted (combinational)
//   rx_data   out  [31:0] received sample, stable while rx_valid=1
//   rx_valid  out  rx_data is valid
//   rx_ready  in   sink accepts rx_data
//   paddr     out  [31:0] APB address
//   pwdata    out  [31:0] APB write data
//   pwrite    out  APB direction, 1 = write
//   penable   out  APB access phase
//   prdata    in   [31:0] APB read data, sampled at the end of the access phase
//   busy      out  high in every state except IDLE
module i2s_apb_streamer #(
  parameter logic [31:0] OFFSET    = 32'h0,
  parameter logic [31:0] TX_ADDR   = 32'h0,
  parameter logic [31:0] RX_ADDR   = 32'h4,
  parameter logic [31:0] STAT_ADDR = 32'h8
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        en,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        penable,
  input  logic [31:0] prdata,
  output logic        busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned FW = 4;

  // Absolute register addresses; the sums wrap modulo 2^32.
  localparam logic [AW-1:0] TX_PADDR   = AW'(OFFSET + TX_ADDR);
  localparam logic [AW-1:0] RX_PADDR   = AW'(OFFSET + RX_ADDR);
  localparam logic [AW-1:0] STAT_PADDR = AW'(OFFSET + STAT_ADDR);

  // Status flag bit positions: {tx_full, tx_empty, rx_full, rx_empty}
  localparam int unsigned FLAG_TX_FULL  = 3;
  localparam int unsigned FLAG_RX_EMPTY = 0;

  typedef enum logic [2:0] {
    IDLE,
    POLL_S,
    POLL_A,
    DECIDE,
    TX_S,
    TX_A,
    RX_S,
    RX_A
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [FW-1:0] flags_q;
  logic [FW-1:0] flags_d;
  logic [AW-1:0] paddr_d;
  logic [DW-1:0] pwdata_d;
  logic          pwrite_d;
  logic          penable_d;
  logic [DW-1:0] rx_data_d;
  logic          rx_valid_d;
  logic          busy_d;
  logic          tx_grant_c;
  logic          rx_grant_c;

  // Arbitration in DECIDE: Tx first, Rx only when the sink slot is free.
  always_comb begin
    tx_grant_c = 1'b0;
    rx_grant_c = 1'b0;
    if (state_q == DECIDE) begin
      tx_grant_c = tx_valid && !flags_q[FLAG_TX_FULL];
      rx_grant_c = !tx_grant_c && !flags_q[FLAG_RX_EMPTY] && !rx_valid;
    end
  end

  // tx_ready must pulse in the DECIDE cycle itself, so it is the grant term.
  always_comb begin
    tx_ready = tx_grant_c;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    paddr_d    = paddr;
    pwdata_d   = pwdata;
    pwrite_d   = 1'b0;
    penable_d  = 1'b0;
    rx_data_d  = rx_data;
    rx_valid_d = rx_valid && !rx_ready;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = POLL_S;
      end
      POLL_S: begin
        state_d = POLL_A;
      end
      POLL_A: begin
        flags_d = prdata[FW-1:0];
        state_d = DECIDE;
      end
      DECIDE: begin
        if (tx_grant_c) begin
          pwdata_d = tx_data;
          state_d  = TX_S;
        end else if (rx_grant_c) begin
          state_d = RX_S;
        end else begin
          state_d = en ? POLL_S : IDLE;
        end
      end
      TX_S: begin
        state_d = TX_A;
      end
      TX_A: begin
        state_d = en ? POLL_S : IDLE;
      end
      RX_S: begin
        state_d = RX_A;
      end
      RX_A: begin
        rx_data_d  = prdata;
        rx_valid_d = 1'b1;
        state_d    = en ? POLL_S : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus outputs are registered from the state being entered so that
    // paddr/pwrite/pwdata are stable across both phases of a transfer.
    unique case (state_d)
      POLL_S, POLL_A: begin
        paddr_d = STAT_PADDR;
      end
      TX_S, TX_A: begin
        paddr_d  = TX_PADDR;
        pwrite_d = 1'b1;
      end
      RX_S, RX_A: begin
        paddr_d = RX_PADDR;
      end
      default: begin
      end
    endcase

    penable_d = (state_d == POLL_A) || (state_d == TX_A) || (state_d == RX_A);
    busy_d    = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      flags_q  <= '0;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      penable  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      paddr    <= paddr_d;
      pwdata   <= pwdata_d;
      pwrite   <= pwrite_d;
      penable  <= penable_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2s_apb_streamer.sv
// Bench for i2s_apb_streamer. Base offset near the top of the address space
// so the register addresses wrap: STAT=0x4, RX=0x0, TX=0xFFFF_FFFC.
module tb_i2s_apb_streamer;

  localparam logic [31:0] OFFSET = 32'hFFFF_FFFC;
  localparam logic [31:0] A_STAT = 32'h0000_0004;
  localparam logic [31:0] A_RX   = 32'h0000_0000;
  localparam logic [31:0] A_TX   = 32'hFFFF_FFFC;

  logic        pclk;
  logic        preset;
  logic        en;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic [31:0] prdata;
  logic        busy;

  // Transceiver model
  logic [3:0]  stat;
  logic [31:0] rx_word;

  assign prdata = (paddr == A_STAT) ? {28'd0, stat} :
                  (paddr == A_RX)   ? rx_word : 32'hDEAD_BEEF;

  i2s_apb_streamer #(.OFFSET(OFFSET)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .en      (en),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pwrite  (pwrite),
    .penable (penable),
    .prdata  (prdata),
    .busy    (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Scoreboards and event log (0 = poll, 1 = write, 2 = rx read)
  logic [31:0] exp_wr[$];
  logic [31:0] exp_rx[$];
  int          ev[$];
  int          cyc = 0;
  int          n_wr = 0;
  int          n_poll = 0;
  int          n_rxrd = 0;
  int          n_txr = 0;
  int          wr_cyc = 0;
  logic [31:0] prev_paddr = '0;
  logic        prev_penable = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  // Bus monitor, sampled on the falling edge.
  always @(negedge pclk) begin
    if (!preset) begin
      if (penable) begin
        chk("apb_setup_before_access", 32'(prev_penable), 0);
        chk("apb_addr_hold", paddr, prev_paddr);
        if (pwrite) begin
          n_wr++;
          wr_cyc = cyc;
          ev.push_back(1);
          chk("wr_addr", paddr, A_TX);
          chk("wr_expected", 32'(exp_wr.size()), 1);
          if (exp_wr.size() > 0) chk("wr_data", pwdata, exp_wr.pop_front());
        end else if (paddr == A_STAT) begin
          n_poll++;
          ev.push_back(0);
        end else begin
          n_rxrd++;
          ev.push_back(2);
          chk("rd_addr", paddr, A_RX);
        end
      end
      if (tx_ready) begin
        n_txr++;
        chk("txr_implies_valid", 32'(tx_valid), 1);
      end
      if (rx_valid && rx_ready) begin
        chk("rx_expected", 32'(exp_rx.size() > 0), 1);
        if (exp_rx.size() > 0) chk("rx_data", rx_data, exp_rx.pop_front());
      end
    end
    prev_paddr   = paddr;
    prev_penable = penable;
  end

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    preset   = 1'b1;
    en       = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    step(2);
    preset = 1'b0;
    step(1);
    n_wr   = 0;
    n_poll = 0;
    n_rxrd = 0;
    n_txr  = 0;
    ev.delete();
  endtask

  // Wait for the tx_ready pulse, then withdraw tx_valid after the accepting edge.
  task automatic grant_tx(input string tag);
    int i;
    i = 0;
    while (!tx_ready && i < 60) begin
      @(negedge pclk);
      i++;
    end
    chk(tag, 32'(tx_ready), 1);
    @(posedge pclk);
    #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int c0;
    int iw;
    int ir;

    preset   = 1'b1;
    en       = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b0;
    stat     = 4'b0101;
    rx_word  = '0;
    step(2);
    chk("rst_ctl", 32'({busy, penable, pwrite, tx_ready, rx_valid}), 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rx_data", rx_data, 0);
    preset = 1'b0;
    step(5);
    chk("idle_no_en_busy", 32'(busy), 0);
    chk("idle_no_en_polls", n_poll, 0);

    // Tx path
    do_reset();
    stat     = 4'b0101;
    tx_data  = 32'hA5A5_0001;
    tx_valid = 1'b1;
    exp_wr.push_back(tx_data);
    en = 1'b1;
    c0 = cyc;
    grant_tx("A_tx_ready");
    en = 1'b0;
    for (int i = 0; i < 40 && n_wr < 1; i++) @(negedge pclk);
    chk("A_latency", 32'(wr_cyc - c0), 5);
    step(3);
    chk("A_idle", 32'(busy), 0);
    chk("A_tx_ready_once", n_txr, 1);
    chk("A_events", 32'(ev.size()), 2);
    if (ev.size() == 2) begin
      chk("A_first_poll", ev[0], 0);
      chk("A_then_write", ev[1], 1);
    end

    // Tx full: polls only until the FIFO drains
    do_reset();
    stat     = 4'b1001;
    tx_data  = 32'h1234_5678;
    tx_valid = 1'b1;
    exp_wr.push_back(tx_data);
    en = 1'b1;
    step(20);
    chk("B_no_write", n_wr, 0);
    chk("B_no_tx_ready", n_txr, 0);
    chk("B_polling", 32'(n_poll >= 3), 1);
    stat = 4'b0001;
    c0   = cyc;
    grant_tx("B_tx_ready");
    for (int i = 0; i < 40 && n_wr < 1; i++) @(negedge pclk);
    chk("B_write_done", n_wr, 1);
    chk("B_within_5", 32'((wr_cyc - c0) <= 5), 1);
    @(posedge pclk);
    #1;
    en = 1'b0;
    step(6);
    chk("B_idle", 32'(busy), 0);

    // Rx backpressure
    do_reset();
    stat    = 4'b0100;
    rx_word = 32'h0000_BEEF;
    exp_rx.push_back(rx_word);
    en = 1'b1;
    step(30);
    chk("C_one_read", n_rxrd, 1);
    chk("C_rx_valid_held", 32'(rx_valid), 1);
    chk("C_rx_data_held", rx_data, 32'h0000_BEEF);
    rx_word = 32'h0000_CAFE;
    exp_rx.push_back(rx_word);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("C_rx_valid_clear", 32'(rx_valid), 0);
    for (int i = 0; i < 40 && n_rxrd < 2; i++) @(negedge pclk);
    chk("C_second_read", n_rxrd, 2);
    @(posedge pclk);
    #1;
    en = 1'b0;
    step(6);
    chk("C_idle", 32'(busy), 0);
    chk("C_rx_data_2", rx_data, 32'h0000_CAFE);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;

    // Arbitration: both eligible, Tx goes first
    do_reset();
    stat     = 4'b0000;
    tx_data  = 32'hDEAD_0043;
    tx_valid = 1'b1;
    exp_wr.push_back(tx_data);
    rx_word = 32'h0000_0043;
    exp_rx.push_back(rx_word);
    en = 1'b1;
    grant_tx("D_tx_ready");
    for (int i = 0; i < 40 && n_rxrd < 1; i++) @(negedge pclk);
    chk("D_read_done", n_rxrd, 1);
    @(posedge pclk);
    #1;
    en = 1'b0;
    step(6);
    chk("D_idle", 32'(busy), 0);
    iw = -1;
    ir = -1;
    foreach (ev[k]) begin
      if (ev[k] == 1 && iw < 0) iw = k;
      if (ev[k] == 2 && ir < 0) ir = k;
    end
    chk("D_write_before_read", 32'(iw >= 0 && ir > iw), 1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;

    // Reset during TX_A: the interrupted write is never seen or retried
    do_reset();
    stat     = 4'b0101;
    tx_data  = 32'h5555_AAAA;
    tx_valid = 1'b1;
    en       = 1'b1;
    grant_tx("E_tx_ready");
    step(1);
    chk("E_in_tx_access", 32'({penable, pwrite}), 3);
    chk("E_tx_pwdata", pwdata, 32'h5555_AAAA);
    preset = 1'b1;
    #1;
    chk("E_rst_ctl", 32'({busy, penable, pwrite, tx_ready, rx_valid}), 0);
    chk("E_rst_paddr", paddr, 0);
    chk("E_rst_pwdata", pwdata, 0);
    step(2);
    preset = 1'b0;
    step(1);
    chk("E_restart_paddr", paddr, A_STAT);
    chk("E_restart_ctl", 32'({busy, penable, pwrite}), 3'b100);
    step(1);
    chk("E_poll_access", 32'(penable), 1);
    en = 1'b0;
    step(6);
    chk("E_no_retry", n_wr, 0);
    chk("E_idle", 32'(busy), 0);

    // en dropped during RX_S: the read completes, then IDLE
    do_reset();
    stat    = 4'b0100;
    rx_word = 32'h0000_0045;
    exp_rx.push_back(rx_word);
    en = 1'b1;
    for (int i = 0; i < 40 && !(busy && !penable && paddr == A_RX); i++) @(negedge pclk);
    chk("F_in_rx_setup", 32'({busy, penable, pwrite}), 3'b100);
    chk("F_rx_setup_addr", paddr, A_RX);
    en = 1'b0;
    step(1);
    chk("F_rx_access", 32'(penable), 1);
    step(1);
    chk("F_idle", 32'(busy), 0);
    chk("F_rx_valid", 32'(rx_valid), 1);
    chk("F_rx_data", rx_data, 32'h0000_0045);
    chk("F_one_read", n_rxrd, 1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(2);

    chk("end_wr_queue", 32'(exp_wr.size()), 0);
    chk("end_rx_queue", 32'(exp_rx.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_apb_streamer.md
I2S_APB_STREAMER -- requirements
Module: i2s_apb_streamer

Interface
REQ-001 Parameter OFFSET, default 0: base address of the I2S transceiver, added to every register address below.
REQ-002 Parameter TX_ADDR, default 32'h0: transmit-data register offset (write).
REQ-003 Parameter RX_ADDR, default 32'h4: receive-data register offset (read).
REQ-004 Parameter STAT_ADDR, default 32'h8: status register offset (read); prdata[3:0] = {Tx_full, Tx_empty, Rx_full, Rx_empty}.
REQ-005 Clock and reset: one clock and asynchronous active-high reset.
REQ-006 pclk  input  1  Sole clock; all state changes on its rising edge.
REQ-007 preset  input  1  Asynchronous reset, active-high.
REQ-008 en  input  1  Enables transfer scheduling.
REQ-009 tx_data  input  32  Sample to transmit.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  One-cycle pulse: tx_data accepted this cycle.
REQ-012 rx_data  output  32  Received sample, held while rx_valid=1.
REQ-013 rx_valid  output  1  rx_data is valid.
REQ-014 rx_ready  input  1  Sink accepts rx_data.
REQ-015 paddr  output  32  APB address.
REQ-016 pwdata  output  32  APB write data.
REQ-017 pwrite  output  1  APB direction, 1 = write.
REQ-018 penable  output  1  APB access phase.
REQ-019 prdata  input  32  APB read data, valid during the access phase.
REQ-020 busy  output  1  High in every state except IDLE.

Function
REQ-021 FSM states: IDLE, POLL_S, POLL_A, DECIDE, TX_S, TX_A, RX_S, RX_A.
REQ-022 Every APB transfer has two cycles and no wait states: *_S (penable=0) followed by *_A (penable=1). paddr, pwrite and pwdata hold constant across both cycles.
REQ-023 IDLE -> POLL_S when en=1.
REQ-024 POLL_S and POLL_A: paddr=OFFSET+STAT_ADDR, pwrite=0. At the end of POLL_A, the block registers prdata[3:0] into flags. Next state is DECIDE.
REQ-025 DECIDE, priority 1: if tx_valid=1 and flags[3]=0, pulse tx_ready, latch tx_data into pwdata, and go to TX_S.
REQ-026 DECIDE, priority 2: otherwise, if flags[0]=0 and rx_valid=0, go to RX_S.
REQ-027 DECIDE, otherwise: go to POLL_S if en=1, else IDLE.
REQ-028 TX_S and TX_A: paddr=OFFSET+TX_ADDR, pwrite=1. After TX_A, go to POLL_S if en=1, else IDLE.
REQ-029 RX_S and RX_A: paddr=OFFSET+RX_ADDR, pwrite=0. At the end of RX_A, the block captures prdata into rx_data and sets rx_valid=1. Next state follows REQ-028.
REQ-030 rx_valid clears on the cycle after rx_valid&rx_ready=1. rx_data is unchanged while rx_valid=1.
REQ-031 Transmit latency: exactly 5 cycles from POLL_S entry to completion of TX_A. Minimum steady-state period is 5 cycles per transmitted sample.
REQ-032 Deasserting en never truncates an APB transfer. The current transfer completes, then the FSM goes to IDLE at the next decision point.
REQ-033 Tx is granted over Rx when both are eligible in the same DECIDE cycle. No starvation guarantee is required for Rx.
REQ-034 With rx_valid=1, no Rx read is issued, so no sample is lost under sink backpressure.
REQ-035 tx_ready is never asserted outside DECIDE. tx_ready=1 implies tx_valid=1.
REQ-036 Address arithmetic is 32-bit modulo 2^32; carry out is discarded.

Reset
REQ-037 While preset=1: state=IDLE, penable=0, pwrite=0, paddr=0, pwdata=0, tx_ready=0, rx_valid=0, rx_data=0, flags=0, busy=0. These values hold from the asserting edge with no clock required.
REQ-038 Reset asserted mid-transfer drops penable and pwrite in the same cycle. No partial write is retried after reset release.
REQ-039 After preset falls, the first APB setup phase occurs no earlier than the first rising edge with en=1.

Verification
REQ-040 Bench scenario, Tx path: en=1, tx_valid=1, tx_data=32'hA5A5_0001, status returns 4'b0101. Required: read of OFFSET+8, then write to OFFSET+0 with pwdata=32'hA5A5_0001, penable high on cycle 5, tx_ready pulsed exactly once.
REQ-041 Bench scenario, Tx full: status returns 4'b1001 and tx_valid=1. Required: repeated polls only, no write, tx_ready stays 0. When status changes to 4'b0001, the write follows within 5 cycles.
REQ-042 Bench scenario, Rx backpressure: status returns 4'b0100, prdata on the Rx read = 32'h0000_BEEF, rx_ready=0. Required: one read, rx_data=32'h0000_BEEF, rx_valid=1 held, no further Rx reads. Raising rx_ready for one cycle clears rx_valid, then the next read occurs.
REQ-043 Bench scenario, arbitration: status returns 4'b0000 and tx_valid=1. Required: the Tx write precedes the Rx read.
REQ-044 Bench scenario, reset mid-TX_A: assert preset during TX_A. Required: penable=0 and pwrite=0 immediately, all outputs at reset values, and after release with en=1 the FSM restarts at POLL_S.
REQ-045 Bench scenario, en deassert during RX_S: required RX_A completes, rx_valid=1, then IDLE with busy=0.
